// File: rtl/vx_commit_tx_pkg.sv
// Shared configuration, tracker state type and lane-expansion helper for the
// commit transmit slice.
package vx_commit_tx_pkg;

  localparam int NUM_THREADS = 4;
  localparam int NUM_WARPS   = 4;
  localparam int NW_WIDTH    = 2;
  localparam int XLEN        = 32;
  localparam int UUID_WIDTH  = 8;
  localparam int PC_BITS     = 32;
  localparam int NR_BITS     = 6;
  localparam int RRS_WIS_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } commit_tx_state_e;

  typedef struct packed {
    logic [NUM_THREADS-1:0]      tmask;
    logic [NUM_THREADS*XLEN-1:0] data;
  } expand_t;

  // Inputs arrive zero-extended to thread width; lane l of packet pid lands on
  // thread pid*lanes+l and every other thread stays zero.
  function automatic expand_t expand_lanes(input int unsigned              pid,
                                           input int unsigned              lanes,
                                           input logic [NUM_THREADS-1:0]      tmask,
                                           input logic [NUM_THREADS*XLEN-1:0] data);
    expand_t r;
    r.tmask = tmask << (pid * lanes);
    r.data  = data << (pid * lanes * XLEN);
    return r;
  endfunction

endpackage

// File: rtl/vx_commit_tx_buf.sv
// Two-entry registered FIFO. Both sides use valid/ready: a beat transfers on
// the cycle valid && ready; out_data holds steady while out_valid && !out_ready.
module vx_commit_tx_buf #(
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data
);

  logic [DATAW-1:0] mem_q [2];
  logic [DATAW-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             wr_fire, rd_fire;

  // When full, a draining head frees its slot on the same edge the new beat is
  // written into it, so the writer is allowed through.
  assign in_ready  = (count_q != 2'd2) || out_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ wr_fire;
    rd_ptr_d = rd_ptr_q ^ rd_fire;
    count_d  = count_q;
    if (wr_fire) mem_d[wr_ptr_q] = in_data;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/vx_commit_tx.sv
// Commit transmit end: expands lane-narrow results to thread-wide commit
// packets, queues them in a 2-entry FIFO and tracks per-warp sop/pid/eop order.
module vx_commit_tx
  import vx_commit_tx_pkg::*;
#(
  parameter int NUM_LANES = NUM_THREADS,
  parameter int PID_BITS  = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [UUID_WIDTH-1:0]         in_uuid,
  input  logic [NW_WIDTH-1:0]           in_wid,
  input  logic [NUM_LANES-1:0]          in_tmask,
  input  logic [PC_BITS-1:0]            in_PC,
  input  logic                          in_wb,
  input  logic [NR_BITS-1:0]            in_rd,
  input  logic [NUM_LANES*XLEN-1:0]     in_data,
  input  logic [PID_BITS-1:0]           in_pid,
  input  logic                          in_sop,
  input  logic                          in_eop,
  input  logic [RRS_WIS_W-1:0]          in_rrs_id,
  output logic                          commit_if_valid,
  input  logic                          commit_if_ready,
  output logic [RRS_WIS_W-1:0]          commit_if_rrs_id,
  output logic [UUID_WIDTH-1:0]         commit_if_uuid,
  output logic [NW_WIDTH-1:0]           commit_if_wid,
  output logic [NUM_THREADS-1:0]        commit_if_tmask,
  output logic [PC_BITS-1:0]            commit_if_PC,
  output logic                          commit_if_wb,
  output logic [NR_BITS-1:0]            commit_if_rd,
  output logic [NUM_THREADS*XLEN-1:0]   commit_if_data,
  output logic [PID_BITS-1:0]           commit_if_pid,
  output logic                          commit_if_sop,
  output logic                          commit_if_eop,
  output logic [NUM_WARPS-1:0]          busy_warps,
  output logic                          seq_err,
  output logic                          seq_err_sticky
);

  localparam int RATIO   = NUM_THREADS / NUM_LANES;
  localparam int TDATA_W = NUM_THREADS * XLEN;
  localparam int DATAW   = RRS_WIS_W + UUID_WIDTH + NW_WIDTH + NUM_THREADS + PC_BITS + 1
                         + NR_BITS + TDATA_W + PID_BITS + 2;

  logic [PID_BITS-1:0] pid_eff;
  expand_t             exp_w;
  logic [DATAW-1:0]    in_vec, out_vec;
  logic                in_fire;

  // A single-packet instruction carries no meaningful pid.
  assign pid_eff = (RATIO == 1) ? '0 : in_pid;
  assign in_fire = in_valid && in_ready;

  always_comb begin
    exp_w = expand_lanes(32'(pid_eff), NUM_LANES, NUM_THREADS'(in_tmask), TDATA_W'(in_data));
  end

  assign in_vec = {in_rrs_id, in_uuid, in_wid, exp_w.tmask, in_PC, in_wb, in_rd,
                   exp_w.data, pid_eff, in_sop, in_eop};

  vx_commit_tx_buf #(
    .DATAW (DATAW)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_vec),
    .out_valid (commit_if_valid),
    .out_ready (commit_if_ready),
    .out_data  (out_vec)
  );

  assign {commit_if_rrs_id, commit_if_uuid, commit_if_wid, commit_if_tmask, commit_if_PC,
          commit_if_wb, commit_if_rd, commit_if_data, commit_if_pid, commit_if_sop,
          commit_if_eop} = out_vec;

  commit_tx_state_e    state_q   [NUM_WARPS];
  commit_tx_state_e    state_d   [NUM_WARPS];
  logic [PID_BITS-1:0] exp_pid_q [NUM_WARPS];
  logic [PID_BITS-1:0] exp_pid_d [NUM_WARPS];
  logic                seq_err_q, seq_err_d;
  logic                sticky_q, sticky_d;
  logic                trk_err;

  // Violations only raise flags; the packet itself is always queued.
  always_comb begin
    state_d   = state_q;
    exp_pid_d = exp_pid_q;
    trk_err   = 1'b0;
    if (in_fire) begin
      if (in_sop) begin
        if (state_q[in_wid] == OPEN || pid_eff != '0) trk_err = 1'b1;
        if (in_eop) begin
          state_d[in_wid] = IDLE;
        end else begin
          state_d[in_wid]   = OPEN;
          exp_pid_d[in_wid] = PID_BITS'(1);
        end
      end else if (state_q[in_wid] == IDLE) begin
        trk_err = 1'b1;
      end else begin
        if (pid_eff != exp_pid_q[in_wid]) trk_err = 1'b1;
        exp_pid_d[in_wid] = exp_pid_q[in_wid] + PID_BITS'(1);
        if (in_eop) state_d[in_wid] = IDLE;
      end
      if (in_eop && pid_eff != PID_BITS'(RATIO - 1)) trk_err = 1'b1;
    end
    seq_err_d = trk_err;
    sticky_d  = sticky_q | trk_err;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        state_q[w]   <= IDLE;
        exp_pid_q[w] <= '0;
      end
      seq_err_q <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_pid_q <= exp_pid_d;
      seq_err_q <= seq_err_d;
      sticky_q  <= sticky_d;
    end
  end

  always_comb begin
    busy_warps = '0;
    for (int w = 0; w < NUM_WARPS; w++) busy_warps[w] = (state_q[w] == OPEN);
  end

  assign seq_err        = seq_err_q;
  assign seq_err_sticky = sticky_q;

endmodule
